// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds per-digit BCD frames from a scanned 7-segment bus.
// Optional SEGDEC_DP_EN adds a committed per-digit decimal-point output (dp_out).
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 400_000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  seg_7_display,
  input  logic [7:0]  active_low_anode,
  output logic [31:0] digit_bcd,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        scan_lost
`ifdef SEGDEC_DP_EN
  ,
  output logic [7:0]  dp_out
`endif
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

`ifdef SEGDEC_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
  // The dp bit plays no part in this build, not even in the settle compare.
  logic unused_dp;
  assign unused_dp = seg_7_display[7];
`endif

  logic [7:0]    an_q, an_d, prev_an_q, prev_an_d;
  logic [SW-1:0] seg_q, seg_d, prev_seg_q, prev_seg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          captured_q, captured_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    seen_q, seen_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          lost_q, lost_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [7:0]    valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef SEGDEC_DP_EN
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic [7:0]    dp_q, dp_d;
`endif

  logic [7:0] sel_n;
  logic       sel_ok;
  logic [2:0] idx;
  logic       same;
  logic       cap;
  logic       commit;
  logic       timeout_hit;
  logic [3:0] dec;
  logic [7:0] frame_valid;
  logic       frame_bad;

  always_comb begin
    an_d       = active_low_anode;
    seg_d      = seg_7_display[SW-1:0];
    prev_an_d  = an_q;
    prev_seg_d = seg_q;
  end

  // A select is a digit only when exactly one anode is driven low.
  always_comb begin
    sel_n  = ~an_q;
    sel_ok = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_n[i]) idx = 3'(i);
    end
    same = (an_q == prev_an_q) && (seg_q == prev_seg_q);
  end

  always_comb begin
    case (seg_q[6:0])
      7'h40:   dec = 4'h0;
      7'h79:   dec = 4'h1;
      7'h24:   dec = 4'h2;
      7'h30:   dec = 4'h3;
      7'h19:   dec = 4'h4;
      7'h12:   dec = 4'h5;
      7'h02:   dec = 4'h6;
      7'h78:   dec = 4'h7;
      7'h00:   dec = 4'h8;
      7'h10:   dec = 4'h9;
      7'h7F:   dec = 4'hF;
      default: dec = 4'hE;
    endcase
  end

  // Counter counts matching samples; a capture fires once per dwell.
  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    cap        = 1'b0;
    if (!sel_ok || !same) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      if (cnt_q != SETTLE_C) cnt_d = cnt_q + 1'b1;
      if ((cnt_d == SETTLE_C) && !captured_q) begin
        cap        = 1'b1;
        captured_d = 1'b1;
      end
    end
  end

  always_comb begin
    frame_bad   = 1'b0;
    frame_valid = 8'h00;
    for (int i = 0; i < 8; i++) begin
      frame_valid[i] = (shadow_q[i*4 +: 4] < 4'hA);
      if (shadow_q[i*4 +: 4] == 4'hE) frame_bad = 1'b1;
    end
  end

  always_comb begin
    commit      = (seen_q == 8'hFF);
    idle_d      = idle_q;
    shadow_d    = shadow_q;
    seen_d      = commit ? 8'h00 : seen_q;
    lost_d      = lost_q;
`ifdef SEGDEC_DP_EN
    shadow_dp_d = shadow_dp_q;
`endif
    if (cap) begin
      idle_d                   = '0;
      shadow_d[{idx, 2'b00} +: 4] = dec;
      seen_d[idx]              = 1'b1;
`ifdef SEGDEC_DP_EN
      shadow_dp_d[idx]         = ~seg_q[7];
`endif
    end else if (idle_q != TIMEOUT_C) begin
      idle_d = idle_q + 1'b1;
    end
    timeout_hit = (idle_d == TIMEOUT_C);
    if (cap) begin
      lost_d = 1'b0;
    end else if (timeout_hit) begin
      lost_d = 1'b1;
      seen_d = 8'h00;
    end
  end

  // Published frame only moves on commit; it holds through scan loss.
  always_comb begin
    bcd_d   = commit ? shadow_q    : bcd_q;
    valid_d = commit ? frame_valid : valid_q;
    err_d   = commit ? frame_bad   : err_q;
    done_d  = commit;
`ifdef SEGDEC_DP_EN
    dp_d    = commit ? shadow_dp_q : dp_q;
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      an_q        <= 8'hFF;
      seg_q       <= '1;
      prev_an_q   <= 8'hFF;
      prev_seg_q  <= '1;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      shadow_q    <= 32'hFFFF_FFFF;
      seen_q      <= 8'h00;
      idle_q      <= '0;
      lost_q      <= 1'b0;
      bcd_q       <= 32'hFFFF_FFFF;
      valid_q     <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SEGDEC_DP_EN
      shadow_dp_q <= 8'h00;
      dp_q        <= 8'h00;
`endif
    end else begin
      an_q        <= an_d;
      seg_q       <= seg_d;
      prev_an_q   <= prev_an_d;
      prev_seg_q  <= prev_seg_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      shadow_q    <= shadow_d;
      seen_q      <= seen_d;
      idle_q      <= idle_d;
      lost_q      <= lost_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SEGDEC_DP_EN
      shadow_dp_q <= shadow_dp_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign digit_bcd   = bcd_q;
  assign digit_valid = valid_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign scan_lost   = lost_q;
`ifdef SEGDEC_DP_EN
  assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  seg_7_display;
  logic [7:0]  active_low_anode;
  logic [31:0] digit_bcd;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        frame_err;
  logic        scan_lost;
`ifdef SEGDEC_DP_EN
  logic [7:0]  dp_out;
`endif

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int base;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .seg_7_display    (seg_7_display),
    .active_low_anode (active_low_anode),
    .digit_bcd        (digit_bcd),
    .digit_valid      (digit_valid),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .scan_lost        (scan_lost)
`ifdef SEGDEC_DP_EN
    ,
    .dp_out           (dp_out)
`endif
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (frame_done === 1'b1) frames++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hF: return 8'hFF;
      default: return 8'h55;
    endcase
  endfunction

  task automatic show(input int idx, input logic [7:0] pat, input int dwell);
    active_low_anode = ~(8'd1 << idx);
    seg_7_display    = pat;
    repeat (dwell) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    active_low_anode = 8'hFF;
    seg_7_display    = 8'hFF;
    repeat (n) @(negedge Clk);
  endtask

  task automatic scan(input logic [31:0] vals, input int lo, input int hi, input int dwell);
    for (int i = lo; i <= hi; i++) show(i, seg_of(vals[i*4 +: 4]), dwell);
  endtask

  initial begin
    Rst = 1'b0;
    active_low_anode = 8'hFF;
    seg_7_display = 8'hFF;
    repeat (3) @(negedge Clk);
    check("rst_bcd", digit_bcd, 32'hFFFF_FFFF);
    check("rst_valid", {24'd0, digit_valid}, 32'h0);
    check("rst_done", {31'd0, frame_done}, 32'h0);
    check("rst_err", {31'd0, frame_err}, 32'h0);
    check("rst_lost", {31'd0, scan_lost}, 32'h0);
    Rst = 1'b1;
    @(negedge Clk);

    base = frames;
    scan(32'h8765_4321, 0, 7, 20);
    idle(10);
    check("s1_frames", 32'(frames - base), 32'd1);
    check("s1_bcd", digit_bcd, 32'h8765_4321);
    check("s1_valid", {24'd0, digit_valid}, 32'hFF);
    check("s1_err", {31'd0, frame_err}, 32'h0);

    base = frames;
    scan(32'h0000_F000, 0, 7, 20);
    idle(10);
    check("blank_frames", 32'(frames - base), 32'd1);
    check("blank_bcd", digit_bcd, 32'h0000_F000);
    check("blank_valid", {24'd0, digit_valid}, 32'hF7);
    check("blank_err", {31'd0, frame_err}, 32'h0);

    base = frames;
    scan(32'h76E4_3210, 0, 7, 20);
    idle(10);
    check("bad_frames", 32'(frames - base), 32'd1);
    check("bad_bcd", digit_bcd, 32'h76E4_3210);
    check("bad_valid", {24'd0, digit_valid}, 32'hDF);
    check("bad_err", {31'd0, frame_err}, 32'h1);

    // Digit 2 first shown too briefly, twice, then for exactly SETTLE+1 cycles.
    base = frames;
    scan(32'h2345_6789, 0, 1, 20);
    show(2, seg_of(4'h7), SETTLE - 1);
    scan(32'h2345_6789, 3, 7, 20);
    idle(2);
    check("short_frames0", 32'(frames - base), 32'd0);
    show(2, seg_of(4'h7), SETTLE - 1);
    idle(2);
    check("short_frames1", 32'(frames - base), 32'd0);
    show(2, seg_of(4'h1), SETTLE + 1);
    idle(5);
    check("short_frames2", 32'(frames - base), 32'd1);
    check("short_bcd", digit_bcd, 32'h2345_6189);
    check("short_err", {31'd0, frame_err}, 32'h0);

    // Digits 4..7 captured, then the scan is lost; they must not count afterwards.
    base = frames;
    scan(32'h5555_5555, 4, 7, 10);
    check("lost_pre", {31'd0, scan_lost}, 32'h0);
    idle(TIMEOUT + 5);
    check("lost_set", {31'd0, scan_lost}, 32'h1);
    check("lost_hold_bcd", digit_bcd, 32'h2345_6189);
    check("lost_hold_valid", {24'd0, digit_valid}, 32'hFF);
    scan(32'h3333_3333, 0, 0, 10);
    check("lost_clear", {31'd0, scan_lost}, 32'h0);
    scan(32'h3333_3333, 1, 3, 10);
    check("lost_partial", 32'(frames - base), 32'd0);
    scan(32'h9081_7263, 0, 6, 10);
    check("lost_seven", 32'(frames - base), 32'd0);
    scan(32'h9081_7263, 7, 7, 10);
    idle(3);
    check("lost_full", 32'(frames - base), 32'd1);
    check("lost_bcd", digit_bcd, 32'h9081_7263);

    // Asynchronous reset in the middle of a frame.
    scan(32'h9999_9999, 0, 4, 10);
    #3 Rst = 1'b0;
    #1;
    check("ar_bcd", digit_bcd, 32'hFFFF_FFFF);
    check("ar_valid", {24'd0, digit_valid}, 32'h0);
    check("ar_err", {31'd0, frame_err}, 32'h0);
    check("ar_done", {31'd0, frame_done}, 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    base = frames;
    scan(32'h0123_4567, 5, 7, 10);
    idle(3);
    check("ar_partial", 32'(frames - base), 32'd0);
    scan(32'h0123_4567, 0, 7, 10);
    idle(3);
    check("ar_frames", 32'(frames - base), 32'd1);
    check("ar_new_bcd", digit_bcd, 32'h0123_4567);
    check("ar_new_valid", {24'd0, digit_valid}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
